// File: rtl/safecrack_btn_debounce_if.sv
// Button conditioning bus: raw active-low pins in, debounced levels and edge pulses out.
// The slave modport is the debouncer; the master modport is the pin driver / consumer side.
interface safecrack_btn_debounce_if #(
  parameter int unsigned N_BTN = 3
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_db;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             any_press;

  modport master (
    output btn_raw,
    input  btn_db,
    input  btn_press,
    input  btn_release,
    input  any_press
  );

  modport slave (
    input  btn_raw,
    output btn_db,
    output btn_press,
    output btn_release,
    output any_press
  );
endinterface

// File: rtl/safecrack_btn_debounce.sv
// Two-flop synchroniser plus per-channel stable-count debouncer for active-low push-buttons.
// Emits clean levels for the safecrack FSM and one-cycle press/release pulses.
module safecrack_btn_debounce #(
  parameter int unsigned N_BTN     = 3,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  safecrack_btn_debounce_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("safecrack_btn_debounce: DB_CYCLES must be >= 2");
  end

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] db_q;
  logic [N_BTN-1:0] db_d;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] press_d;
  logic [N_BTN-1:0] release_q;
  logic [N_BTN-1:0] release_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

  // Next-state: a level is accepted only after DB_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_d      = db_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]      = sync2_q[i];
        cnt_d[i]     = '0;
        press_d[i]   = ~sync2_q[i];
        release_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // State register; reset forces every channel to released with no pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      db_q      <= '1;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.btn_db      = db_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.any_press   = |press_q;

endmodule

// File: tb/tb_safecrack_btn_debounce.sv
// Directed bench for safecrack_btn_debounce with DB_CYCLES=8.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_safecrack_btn_debounce;

  localparam int unsigned N_BTN     = 3;
  localparam int unsigned DB_CYCLES = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  safecrack_btn_debounce_if #(.N_BTN(N_BTN)) bus_if ();

  safecrack_btn_debounce #(
    .N_BTN     (N_BTN),
    .DB_CYCLES (DB_CYCLES)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] db, input logic [2:0] press,
                            input logic [2:0] rel);
    check_eq({tag, ".db"},      32'(bus_if.btn_db),      32'(db));
    check_eq({tag, ".press"},   32'(bus_if.btn_press),   32'(press));
    check_eq({tag, ".release"}, 32'(bus_if.btn_release), 32'(rel));
    check_eq({tag, ".any"},     32'(bus_if.any_press),   32'(|press));
  endtask

  task automatic run_edge(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a raw pattern for n edges, expecting everything to stay released and quiet.
  task automatic hold_quiet(input string tag, input logic [2:0] v, input int n);
    bus_if.btn_raw = v;
    for (int k = 0; k < n; k++) begin
      run_edge(1);
      check_outs(tag, 3'b111, 3'b000, 3'b000);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst            = 1'b1;
    bus_if.btn_raw = 3'b000;

    // Reset with all buttons held
    run_edge(2);
    check_outs("rst_hold", 3'b111, 3'b000, 3'b000);
    rst = 1'b0;
    run_edge(9);
    check_outs("rst_edge9", 3'b111, 3'b000, 3'b000);
    run_edge(1);
    check_outs("rst_edge10", 3'b000, 3'b111, 3'b000);
    run_edge(1);
    check_outs("rst_edge11", 3'b000, 3'b000, 3'b000);

    // Release everything
    bus_if.btn_raw = 3'b111;
    run_edge(10);
    check_outs("rel_all", 3'b111, 3'b000, 3'b111);
    run_edge(1);
    check_outs("rel_all_after", 3'b111, 3'b000, 3'b000);

    // Clean press and release on ch0
    bus_if.btn_raw = 3'b110;
    run_edge(9);
    check_outs("ch0_press_e9", 3'b111, 3'b000, 3'b000);
    run_edge(1);
    check_outs("ch0_press_e10", 3'b110, 3'b001, 3'b000);
    run_edge(1);
    check_outs("ch0_press_e11", 3'b110, 3'b000, 3'b000);
    bus_if.btn_raw = 3'b111;
    run_edge(9);
    check_outs("ch0_rel_e9", 3'b110, 3'b000, 3'b000);
    run_edge(1);
    check_outs("ch0_rel_e10", 3'b111, 3'b000, 3'b001);
    run_edge(1);
    check_outs("ch0_rel_e11", 3'b111, 3'b000, 3'b000);

    // Bounce on ch1: short lows are rejected, final hold is accepted
    hold_quiet("ch1_lo3", 3'b101, 3);
    hold_quiet("ch1_hi2a", 3'b111, 2);
    hold_quiet("ch1_lo5", 3'b101, 5);
    hold_quiet("ch1_hi2b", 3'b111, 2);
    hold_quiet("ch1_lo7", 3'b101, 7);
    hold_quiet("ch1_hi2c", 3'b111, 2);
    bus_if.btn_raw = 3'b101;
    run_edge(9);
    check_outs("ch1_hold_e9", 3'b111, 3'b000, 3'b000);
    run_edge(1);
    check_outs("ch1_hold_e10", 3'b101, 3'b010, 3'b000);
    run_edge(1);
    check_outs("ch1_hold_e11", 3'b101, 3'b000, 3'b000);
    bus_if.btn_raw = 3'b111;
    run_edge(10);
    check_outs("ch1_rel", 3'b111, 3'b000, 3'b010);

    // Threshold on ch2: 7 cycles rejected
    hold_quiet("ch2_lo7", 3'b011, 7);
    hold_quiet("ch2_lo7_after", 3'b111, 12);

    // Threshold on ch2: 8 cycles accepted, then released
    bus_if.btn_raw = 3'b011;
    run_edge(8);
    check_outs("ch2_lo8_e8", 3'b111, 3'b000, 3'b000);
    bus_if.btn_raw = 3'b111;
    run_edge(1);
    check_outs("ch2_lo8_e9", 3'b111, 3'b000, 3'b000);
    run_edge(1);
    check_outs("ch2_lo8_e10", 3'b011, 3'b100, 3'b000);
    run_edge(7);
    check_outs("ch2_lo8_e17", 3'b011, 3'b000, 3'b000);
    run_edge(1);
    check_outs("ch2_lo8_e18", 3'b111, 3'b000, 3'b100);
    run_edge(1);
    check_outs("ch2_lo8_e19", 3'b111, 3'b000, 3'b000);

    // Simultaneous press on all channels
    bus_if.btn_raw = 3'b000;
    run_edge(9);
    check_outs("sim_e9", 3'b111, 3'b000, 3'b000);
    run_edge(1);
    check_outs("sim_e10", 3'b000, 3'b111, 3'b000);
    run_edge(1);
    check_outs("sim_e11", 3'b000, 3'b000, 3'b000);
    bus_if.btn_raw = 3'b111;
    run_edge(10);
    check_outs("sim_rel", 3'b111, 3'b000, 3'b111);
    run_edge(1);

    // Reset mid-count with ch0 held
    bus_if.btn_raw = 3'b110;
    run_edge(7);
    check_outs("midrst_pre", 3'b111, 3'b000, 3'b000);
    rst = 1'b1;
    run_edge(1);
    check_outs("midrst_r1", 3'b111, 3'b000, 3'b000);
    run_edge(1);
    check_outs("midrst_r2", 3'b111, 3'b000, 3'b000);
    rst = 1'b0;
    run_edge(9);
    check_outs("midrst_e9", 3'b111, 3'b000, 3'b000);
    run_edge(1);
    check_outs("midrst_e10", 3'b110, 3'b001, 3'b000);
    run_edge(1);
    check_outs("midrst_e11", 3'b110, 3'b000, 3'b000);

    // Reset while pressed: immediate release, no release pulse
    rst = 1'b1;
    bus_if.btn_raw = 3'b111;
    run_edge(1);
    check_outs("rst_pressed", 3'b111, 3'b000, 3'b000);
    rst = 1'b0;
    run_edge(12);
    check_outs("rst_pressed_after", 3'b111, 3'b000, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/safecrack_btn_debounce.md
Name: safecrack_btn_debounce

Overview:
- Input-conditioning stage placed directly upstream of the safecrack FSM.
- Synchronises the three raw, active-low, bouncy push-buttons to clk and debounces each one independently.
- Drives clean active-low levels to the FSM's btn input, so the FSM's own 0->1 edge detection sees exactly one edge per physical press.
- Also produces one-cycle press/release pulses and an any-press flag for other consumers.

Parameters:
- N_BTN, 3, number of button channels.
- DB_CYCLES, 1_000_000, number of consecutive stable synchronised cycles required to accept a new level (20 ms at 50 MHz). Legal range is >= 2. The bench uses 8.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset; sampled on posedge clk.
- btn_raw  input  N_BTN  raw button pins, active-low (0 = pressed), asynchronous to clk, may bounce.
- btn_db  output  N_BTN  debounced level, active-low (0 = pressed); connects to the FSM btn port.
- btn_press  output  N_BTN  one-cycle high pulse per channel when btn_db goes 1->0.
- btn_release  output  N_BTN  one-cycle high pulse per channel when btn_db goes 0->1.
- any_press  output  1  OR of btn_press.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - All state updates on posedge clk.
  - Reset is synchronous and active-high.
- Reset values (rst=1 at a posedge):
  - Both synchroniser flops of every channel = 1 (released).
  - btn_db = all ones.
  - Debounce counters = 0.
  - btn_press, btn_release, any_press = 0.
- Synchroniser:
  - Two-flop chain per channel: sync1 <= btn_raw[i], then sync2 <= sync1.
  - No other logic samples btn_raw.
- Per-channel debounce, using counter cnt of width $clog2(DB_CYCLES):
  - sync2 == btn_db[i]: cnt <= 0 and btn_db holds. A bounce back to the current level aborts the pending change.
  - sync2 != btn_db[i] and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - sync2 != btn_db[i] and cnt == DB_CYCLES-1: btn_db[i] <= sync2 and cnt <= 0.
- Latency:
  - A clean level change at btn_raw, set up before posedge e0, appears on btn_db at posedge e(DB_CYCLES+1).
  - That is DB_CYCLES+2 edges after the change.
  - Any excursion of sync2 lasting fewer than DB_CYCLES cycles never reaches btn_db.
- Pulses:
  - btn_press and btn_release are registered and asserted in the same cycle btn_db changes, for exactly one cycle.
  - Only one direction can fire per channel per cycle.
  - any_press is combinational OR of btn_press, i.e. coincident with the pulses.
- Channel independence:
  - Channels share no state.
  - Simultaneous stable presses on several channels produce simultaneous btn_db transitions and simultaneous pulses.
  - The FSM treats a multi-bit edge as a wrong button. That is intended and is not filtered here.
- Boundary conditions:
  - Counter never exceeds DB_CYCLES-1 and never wraps.
  - A level held for exactly DB_CYCLES-1 cycles is rejected.
  - A level held for DB_CYCLES cycles is accepted.
- Reset mid-operation:
  - A pending count is discarded.
  - btn_db returns to released immediately on the reset edge, with no release pulse.
  - A button held through reset is re-qualified and reported as a new press DB_CYCLES+2 edges after rst deasserts.
- X-safety:
  - btn_raw may be X before its first sync stage. No output may go X after reset.
- Outputs are level-stable between transitions and carry no combinational path from btn_raw.

Test Plan (DB_CYCLES=8):
- Reset: assert rst 2 cycles with btn_raw=3'b000 -> during reset btn_db=3'b111 and pulses=0. After deassert, btn_db=3'b000 exactly 10 edges later, with btn_press=3'b111 for 1 cycle and any_press=1 in that cycle.
- Clean press on ch0: btn_raw 111->110 and held -> btn_db=110 at edge 10, btn_press=001 for 1 cycle, no change at edge 9. Then release 110->111 -> btn_db=111 after 10 edges and btn_release=001 for 1 cycle.
- Bounce filter on ch1: toggle btn_raw[1] with low pulses of 3, 5 and 7 cycles separated by 2-cycle highs, then hold low -> btn_db[1] falls exactly 10 edges after the final falling edge, with a single btn_press[1] pulse.
- Threshold: hold btn_raw[2] low for 7 cycles then high -> no change and no pulse. Repeat with 8 cycles -> btn_db[2] pulses low, giving btn_press[2] followed later by btn_release[2].
- Simultaneous: drive btn_raw 111->000 in one cycle -> all three btn_db bits fall in the same cycle and btn_press=111 for 1 cycle.
- Reset mid-count: press ch0 and assert rst at count 5 while btn_raw stays 110 -> btn_db stays 111 with no pulses during reset. After deassert, btn_press=001 exactly 10 edges later.
